// File: rtl/riscv_dmem_responder_pkg.sv
// Shared dmem message constants and types used by the core and the responder.
package riscv_dmem_responder_pkg;

  localparam int DMEM_TYPE_W = 2;
  localparam int DMEM_LEN_W  = 2;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_RESP_W = DMEM_TYPE_W + DMEM_DATA_W;

  typedef enum logic [DMEM_TYPE_W-1:0] {
    DMEM_NR = 2'd0,
    DMEM_LD = 2'd1,
    DMEM_ST = 2'd2
  } dmem_type_e;

  typedef enum logic [DMEM_LEN_W-1:0] {
    DMEM_ML_W = 2'd0,
    DMEM_ML_B = 2'd1,
    DMEM_ML_H = 2'd2
  } dmem_len_e;

  typedef struct packed {
    logic [DMEM_TYPE_W-1:0] msg_type;
    logic [DMEM_DATA_W-1:0] data;
  } dmem_resp_t;

endpackage

// File: rtl/riscv_dmem_resp_queue.sv
// Two-entry in-order response FIFO; the head entry is always in head_reg.
module riscv_dmem_resp_queue #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  output logic             enq_rdy,
  input  logic [WIDTH-1:0] enq_msg,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] deq_msg
);

  logic [1:0]       count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] tail_reg, tail_next;
  logic             enq_fire, deq_fire;

  assign enq_rdy  = (count_reg != 2'd2);
  assign deq_val  = (count_reg != 2'd0);
  assign deq_msg  = head_reg;
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  // Dequeue is applied first so an enqueue at count 1 lands in the freed head.
  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (deq_fire) begin
      head_next  = tail_reg;
      tail_next  = '0;
      count_next = count_reg - 2'd1;
    end
    if (enq_fire) begin
      if (count_next == 2'd0) head_next = enq_msg;
      else                    tail_next = enq_msg;
      count_next = count_next + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= 2'd0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      count_reg <= count_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: word scratchpad with sub-word access and an in-order response queue.
// Define RISCV_DMEM_MISALIGN_CHECK_EN to flag misaligned word/half accesses as errors.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h00080000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic [1:0]  dmemreq_msg_type,
  input  logic [1:0]  dmemreq_msg_len,
  input  logic [31:0] dmemreq_msg_addr,
  input  logic [31:0] dmemreq_msg_data,
  output logic        dmemresp_val,
  input  logic        dmemresp_rdy,
  output logic [1:0]  dmemresp_msg_type,
  output logic [31:0] dmemresp_msg_data,
  output logic        addr_err
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]      mem [MEM_WORDS];
  logic [29:0]      word_off;
  logic [IDX_W-1:0] idx;
  logic             out_of_range, misaligned, acc_err;
  logic             is_ld, is_st, is_b, is_h;
  logic             accept, enq_val, enq_rdy, wr_en;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data, rd_word, rd_shifted, ld_data, resp_data;
  logic [4:0]       shamt;
  dmem_resp_t       enq_msg, deq_msg;

  assign is_ld = (dmemreq_msg_type == DMEM_LD);
  assign is_st = (dmemreq_msg_type == DMEM_ST);
  assign is_b  = (dmemreq_msg_len == DMEM_ML_B);
  assign is_h  = (dmemreq_msg_len == DMEM_ML_H);

  assign word_off     = dmemreq_msg_addr[31:2] - BASE_ADDR[31:2];
  assign idx          = word_off[IDX_W-1:0];
  assign out_of_range = (dmemreq_msg_addr < BASE_ADDR) || (word_off >= 30'(MEM_WORDS));

`ifdef RISCV_DMEM_MISALIGN_CHECK_EN
  assign misaligned = (dmemreq_msg_len == DMEM_ML_W && dmemreq_msg_addr[1:0] != 2'b00) ||
                      (is_h && dmemreq_msg_addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  assign acc_err = out_of_range || misaligned;

  // Per-lane enables; store data is replicated so each lane picks its own byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_en[gi] = is_b ? (dmemreq_msg_addr[1:0] == 2'(gi)) :
                         is_h ? (dmemreq_msg_addr[1] == 1'(gi / 2)) : 1'b1;
    assign wr_data[gi*8 +: 8] = is_b ? dmemreq_msg_data[7:0] :
                                is_h ? dmemreq_msg_data[(gi % 2)*8 +: 8] :
                                       dmemreq_msg_data[gi*8 +: 8];
  end

  assign accept  = dmemreq_val && dmemreq_rdy;
  assign enq_val = dmemreq_val && (is_ld || is_st);
  assign wr_en   = accept && is_st && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  assign rd_word    = mem[idx];
  assign shamt      = is_b ? {dmemreq_msg_addr[1:0], 3'b000} :
                      is_h ? {dmemreq_msg_addr[1], 4'b0000} : 5'd0;
  assign rd_shifted = rd_word >> shamt;
  assign ld_data    = is_b ? {24'h0, rd_shifted[7:0]} :
                      is_h ? {16'h0, rd_shifted[15:0]} : rd_shifted;
  assign resp_data  = (is_ld && !acc_err) ? ld_data : 32'h0;

  assign enq_msg.msg_type = dmemreq_msg_type;
  assign enq_msg.data     = resp_data;

  riscv_dmem_resp_queue #(.WIDTH(DMEM_RESP_W)) u_resp_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .enq_rdy (enq_rdy),
    .enq_msg (enq_msg),
    .deq_val (dmemresp_val),
    .deq_rdy (dmemresp_rdy),
    .deq_msg (deq_msg)
  );

  assign dmemreq_rdy       = enq_rdy;
  assign dmemresp_msg_type = deq_msg.msg_type;
  assign dmemresp_msg_data = deq_msg.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           addr_err <= 1'b0;
    else if (enq_val && enq_rdy && acc_err) addr_err <= 1'b1;
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Randomized and directed bench for riscv_dmem_responder against a byte-addressed model.
module tb_riscv_dmem_responder;

  localparam int          NW   = 1024;
  localparam logic [31:0] BASE = 32'h00080000;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] d;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_val = 1'b0;
  logic        dmemreq_rdy;
  logic [1:0]  req_type = 2'd0;
  logic [1:0]  req_len = 2'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        dmemresp_val;
  logic        resp_rdy = 1'b1;
  logic [1:0]  dmemresp_msg_type;
  logic [31:0] dmemresp_msg_data;
  logic        addr_err;

  int    checks = 0;
  int    failures = 0;
  bit    rand_rdy = 1'b0;
  resp_t mq[$];
  resp_t got[$];
  logic  merr = 1'b0;
  logic [7:0] mb [256];

  riscv_dmem_responder #(.MEM_WORDS(NW), .BASE_ADDR(BASE)) dut (
    .clk               (clk),
    .reset             (reset),
    .dmemreq_val       (req_val),
    .dmemreq_rdy       (dmemreq_rdy),
    .dmemreq_msg_type  (req_type),
    .dmemreq_msg_len   (req_len),
    .dmemreq_msg_addr  (req_addr),
    .dmemreq_msg_data  (req_data),
    .dmemresp_val      (dmemresp_val),
    .dmemresp_rdy      (resp_rdy),
    .dmemresp_msg_type (dmemresp_msg_type),
    .dmemresp_msg_data (dmemresp_msg_data),
    .addr_err          (addr_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic m_err(logic [1:0] l, logic [31:0] a);
    logic e;
    e = (a < BASE) || ((a - BASE) >= 32'(4 * NW));
`ifdef RISCV_DMEM_MISALIGN_CHECK_EN
    if (l == 2'd0 && a[1:0] != 2'b00) e = 1'b1;
    if (l == 2'd2 && a[0]) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int nbytes(logic [1:0] l);
    return (l == 2'd1) ? 1 : (l == 2'd2) ? 2 : 4;
  endfunction

  function automatic int m_off(logic [1:0] l, logic [31:0] a);
    logic [31:0] b;
    b = a - BASE;
    return int'(b) / nbytes(l) * nbytes(l);
  endfunction

  function automatic logic [31:0] m_load(logic [1:0] l, logic [31:0] a);
    logic [31:0] v;
    int off;
    v = 32'h0;
    off = m_off(l, a);
    for (int i = 0; i < nbytes(l); i++) v[8*i +: 8] = mb[off + i];
    return v;
  endfunction

  function automatic void m_store(logic [1:0] l, logic [31:0] a, logic [31:0] d);
    int off;
    off = m_off(l, a);
    for (int i = 0; i < nbytes(l); i++) mb[off + i] = d[8*i +: 8];
  endfunction

  // Compare DUT against the model, then advance the model to the coming edge.
  always @(negedge clk) begin
    resp_t e;
    bit    full;
    logic  er;
    if (reset) begin
      mq.delete();
      merr = 1'b0;
      chk("reset_val", {31'h0, dmemresp_val}, 32'h0);
    end else begin
      chk("resp_val", {31'h0, dmemresp_val}, {31'h0, mq.size() != 0});
      chk("req_rdy", {31'h0, dmemreq_rdy}, {31'h0, mq.size() != 2});
      chk("addr_err", {31'h0, addr_err}, {31'h0, merr});
      if (mq.size() != 0) begin
        chk("resp_type", {30'h0, dmemresp_msg_type}, {30'h0, mq[0].t});
        chk("resp_data", dmemresp_msg_data, mq[0].d);
      end
      if (dmemresp_val && resp_rdy) got.push_back('{dmemresp_msg_type, dmemresp_msg_data});
      full = (mq.size() == 2);
      if (mq.size() != 0 && resp_rdy) void'(mq.pop_front());
      if (req_val && !full && (req_type == 2'd1 || req_type == 2'd2)) begin
        er = m_err(req_len, req_addr);
        if (er) merr = 1'b1;
        if (req_type == 2'd2 && !er) m_store(req_len, req_addr, req_data);
        e.t = req_type;
        e.d = (req_type == 2'd1 && !er) ? m_load(req_len, req_addr) : 32'h0;
        mq.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 resp_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [1:0] t, input logic [1:0] l, input logic [31:0] a,
                      input logic [31:0] d);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    req_val = 1'b1; req_type = t; req_len = l; req_addr = a; req_data = d;
    while (!acc) begin
      @(negedge clk);
      acc = dmemreq_rdy;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        chk("send_timeout", 32'h0, 32'h1);
        break;
      end
    end
    req_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mq.size() != 0) chk("drain_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(int i, logic [1:0] t, logic [31:0] d, string nm);
    if (got.size() <= i) begin
      chk({nm, "_missing"}, got.size(), i + 1);
    end else begin
      chk({nm, "_type"}, {30'h0, got[i].t}, {30'h0, t});
      chk({nm, "_data"}, got[i].d, d);
    end
  endtask

  initial begin
    int r;
    logic [1:0]  t, l;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_pin_val", {31'h0, dmemresp_val}, 32'h0);
    chk("rst_pin_rdy", {31'h0, dmemreq_rdy}, 32'h1);
    chk("rst_pin_err", {31'h0, addr_err}, 32'h0);
    chk("rst_pin_msg", dmemresp_msg_data, 32'h0);
    @(posedge clk);
    #1;

    send(2'd2, 2'd0, 32'h00080000, 32'h0BADF00D);
    drain();
    got.delete();
    send(2'd2, 2'd0, 32'h00080010, 32'hDEADBEEF);
    send(2'd1, 2'd0, 32'h00080010, 32'h0);
    send(2'd1, 2'd1, 32'h00080013, 32'h0);
    send(2'd1, 2'd2, 32'h00080012, 32'h0);
    send(2'd2, 2'd1, 32'h00080011, 32'h00000055);
    send(2'd1, 2'd0, 32'h00080010, 32'h0);
    drain();
    chk_got(0, 2'd2, 32'h00000000, "st_word");
    chk_got(1, 2'd1, 32'hDEADBEEF, "ld_word");
    chk_got(2, 2'd1, 32'h000000DE, "ld_byte");
    chk_got(3, 2'd1, 32'h0000DEAD, "ld_half");
    chk_got(4, 2'd2, 32'h00000000, "st_byte");
    chk_got(5, 2'd1, 32'hDEAD55EF, "ld_merged");

    got.delete();
    send(2'd1, 2'd0, 32'h00080002, 32'h0);
    drain();
`ifdef RISCV_DMEM_MISALIGN_CHECK_EN
    chk_got(0, 2'd1, 32'h00000000, "misalign_ld");
    chk("misalign_err", {31'h0, addr_err}, 32'h1);
`else
    chk_got(0, 2'd1, 32'h0BADF00D, "misalign_ld");
    chk("misalign_err", {31'h0, addr_err}, 32'h0);
`endif

    got.delete();
    resp_rdy = 1'b0;
    fork
      begin
        send(2'd1, 2'd0, 32'h00080010, 32'h0);
        send(2'd1, 2'd1, 32'h00080010, 32'h0);
        send(2'd1, 2'd2, 32'h00080010, 32'h0);
      end
    join_none
    repeat (4) @(negedge clk);
    chk("bp_rdy_low", {31'h0, dmemreq_rdy}, 32'h0);
    chk("bp_val_high", {31'h0, dmemresp_val}, 32'h1);
    resp_rdy = 1'b1;
    wait fork;
    drain();
    chk_got(0, 2'd1, 32'hDEAD55EF, "bp_first");
    chk_got(1, 2'd1, 32'h000000EF, "bp_second");
    chk_got(2, 2'd1, 32'h000055EF, "bp_third");

    got.delete();
    send(2'd1, 2'd0, 32'h00081000, 32'h0);
    drain();
    chk_got(0, 2'd1, 32'h00000000, "oob_ld");
    chk("oob_err", {31'h0, addr_err}, 32'h1);
    send(2'd2, 2'd0, 32'h00081000, 32'h12345678);
    send(2'd1, 2'd0, 32'h00080000, 32'h0);
    drain();
    chk_got(2, 2'd1, 32'h0BADF00D, "oob_no_write");

    resp_rdy = 1'b0;
    send(2'd2, 2'd0, 32'h00080020, 32'h11112222);
    send(2'd2, 2'd0, 32'h00080024, 32'h33334444);
    chk("pre_reset_full", {31'h0, dmemreq_rdy}, 32'h0);
    reset = 1'b1;
    #1;
    chk("reset_drop_val", {31'h0, dmemresp_val}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", {31'h0, dmemreq_rdy}, 32'h1);
    chk("post_rst_err", {31'h0, addr_err}, 32'h0);
    chk("post_rst_msg", dmemresp_msg_data, 32'h0);
    @(posedge clk);
    #1;

    rand_rdy = 1'b1;
    for (int i = 0; i < 64; i++) send(2'd2, 2'd0, BASE + 32'(4 * i), $urandom);
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      t = 2'($urandom_range(0, 2));
      l = 2'($urandom_range(0, 2));
      if (r < 85)      a = BASE + 32'($urandom_range(0, 255));
      else if (r < 95) a = BASE + 32'h1000 + 32'($urandom_range(0, 255));
      else             a = BASE - 32'($urandom_range(1, 256));
      send(t, l, a, $urandom);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 resp_rdy = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
